std_square: RTL and testbench
=============================

// Module: std_square
// PURPOSE
//  Iterative shift-add squarer: out = in*in (+ addend, optional), one multiplier bit per cycle.
//  Inverse companion of std_sqrt: recombines a root (and remainder) into the original radicand.
//  Sits in the bitnum math primitive library behind the standard Calyx go/done interface.
// PARAMETERS
//  WIDTH      16          width of operand `in`
//  OUT_WIDTH  2*WIDTH     width of `out`; result truncated to low OUT_WIDTH bits
// PORTS
//  clk     in   1              clock; all state updates on posedge
//  reset   in   1              asynchronous, active-high reset
//  go      in   1              start/hold request (Calyx go)
//  in      in   WIDTH          operand, sampled only at start
//  addend  in   WIDTH+1        (STD_SQUARE_ADDEND_EN only) added to the square, sampled at start
//  out     out  OUT_WIDTH      result, registered, held until next completion
//  done    out  1              one-cycle completion pulse
// BEHAVIOUR
//  - One clock (clk); reset asynchronous, active-high. On reset: state=IDLE, out=0, done=0,
//    acc/mcand/mplier/count=0. Reset mid-operation aborts; no done is produced.
//  - FSM states IDLE, BUSY, DONE.
//    IDLE: go=1 -> latch mcand={WIDTH'0,in}, mplier=in, acc=0 (or addend), count=0; go BUSY.
//    BUSY: if go=0 -> IDLE immediately (abort; out unchanged, no done).
//          else: if mplier[0] then acc+=mcand; mcand<<=1; mplier>>=1; count++;
//          after the WIDTH-th BUSY cycle -> DONE, out<=acc[OUT_WIDTH-1:0].
//    DONE: done=1 for exactly this cycle; unconditionally -> IDLE.
//  - Latency: done high WIDTH+1 edges after the edge sampling go=1 in IDLE; out valid when done=1.
//  - go still high in IDLE after DONE starts a new operation (back-to-back, WIDTH+2 cycle period).
//  - `in`/`addend` changes after start are ignored.
//  - Arithmetic: acc and mcand are 2*WIDTH+1 bits wide, unsigned, no saturation; the carry bit
//    and bits above OUT_WIDTH are discarded.
//  - count is $clog2(WIDTH+1) bits wide and saturates at WIDTH; it never wraps.
//  - done is a registered output decoded from state==DONE; there is no combinational go->done path.
//  - in=0: still takes the full latency, out=0 (no early exit, so the timing is constant).
// CONFIGURATION
//  STD_SQUARE_ADDEND_EN defined: `addend` port present; acc is initialised to addend, so
//    out = in*in + addend. With a std_sqrt root q and remainder r (r<=2q) the sum fits in 2*WIDTH.
//  Not defined: no addend port; acc is initialised to 0; out = in*in.
// STRUCTURE
//  - Shared package std_bitnum_pkg holds:
//    - typedef enum logic [1:0] {IDLE, BUSY, DONE} bitnum_iter_state_t;
//    - function iter_latency(width) = width+1, reused by the std_sqrt bench.
//  - Single flat module; no sub-module (the datapath is one add/shift step).
// TESTING
//  1. WIDTH=16, in=5, go held -> done pulses on cycle 17 after start, out=25; next cycle done=0.
//  2. in=16'hFFFF -> out=32'hFFFE_0001; in=0 -> out=0 with identical latency.
//  3. go held with in=3 then in=4 -> out=9 then out=16, done pulses 18 cycles apart.
//  4. in=7 completes (out=49); next op in=9, go dropped on BUSY cycle 8 -> no done, out stays 49.
//  5. reset asserted mid-BUSY (between edges) -> out=0, done=0 immediately, FSM IDLE.
//  6. ADDEND_EN, in=46340, addend=88047 -> out=32'h7FFF_FFFF; round-trip random std_sqrt outputs.

Source files
------------

// File: rtl/std_bitnum_pkg.sv
// Shared definitions for the bitnum iterative math primitives (std_square, std_sqrt).
// Holds the go/done iteration state encoding and the iteration latency helper.
package std_bitnum_pkg;

    // Iteration state shared by the bit-serial primitives.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bitnum_iter_state_t;

    // Edges from the edge that samples go in IDLE to the edge that raises done.
    function automatic int iter_latency(input int width);
        return width + 32'sd1;
    endfunction

endpackage

// File: rtl/std_square.sv
// std_square: iterative shift-add squarer, out = in*in (+ addend), one multiplier bit per cycle.
// Calyx go/done handshake. Optional feature macro: STD_SQUARE_ADDEND_EN adds an `addend` port
// whose value initialises the accumulator, so a std_sqrt root/remainder pair recombines into
// the original radicand.
module std_square
    import std_bitnum_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 2 * WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [WIDTH-1:0]     in,
`ifdef STD_SQUARE_ADDEND_EN
    input  logic [WIDTH:0]       addend,
`endif
    output logic [OUT_WIDTH-1:0] out,
    output logic                 done
);

    localparam int ACC_W = 2 * WIDTH + 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

    bitnum_iter_state_t   state_r;
    logic [ACC_W-1:0]     acc_r;
    logic [ACC_W-1:0]     mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [CNT_W-1:0]     count_r;
    logic [OUT_WIDTH-1:0] out_r;
    logic                 done_r;

    logic [ACC_W-1:0]     acc_init_s;
    logic [ACC_W-1:0]     acc_step_s;
    logic [ACC_W-1:0]     mcand_step_s;
    logic [WIDTH-1:0]     mplier_step_s;
    logic [CNT_W-1:0]     count_step_s;

    assign out  = out_r;
    assign done = done_r;

    // Accumulator start value: the addend when the feature is built in, zero otherwise.
`ifdef STD_SQUARE_ADDEND_EN
    assign acc_init_s = {{WIDTH{1'b0}}, addend};
`else
    assign acc_init_s = {ACC_W{1'b0}};
`endif

    // One shift-add step: conditional add of the multiplicand, shift both operands, bump count.
    always_comb begin
        acc_step_s    = acc_r;
        mcand_step_s  = {mcand_r[ACC_W-2:0], 1'b0};
        mplier_step_s = {1'b0, mplier_r[WIDTH-1:1]};
        count_step_s  = count_r;
        if (mplier_r[0]) begin
            acc_step_s = acc_r + mcand_r;
        end else begin
            acc_step_s = acc_r;
        end
        // count stops at WIDTH so a stray extra step can never wrap it back into range
        if (count_r == CNT_MAX) begin
            count_step_s = count_r;
        end else begin
            count_step_s = count_r + CNT_W'(1);
        end
    end

    // Control FSM and datapath registers; done is decoded from the DONE state one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            acc_r    <= {ACC_W{1'b0}};
            mcand_r  <= {ACC_W{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            out_r    <= {OUT_WIDTH{1'b0}};
            done_r   <= 1'b0;
        end else begin
            done_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (go) begin
                        mcand_r  <= {{(WIDTH + 1){1'b0}}, in};
                        mplier_r <= in;
                        acc_r    <= acc_init_s;
                        count_r  <= {CNT_W{1'b0}};
                        state_r  <= BUSY;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                BUSY: begin
                    if (!go) begin
                        // abort: result register keeps the previous completion
                        state_r <= IDLE;
                    end else begin
                        acc_r    <= acc_step_s;
                        mcand_r  <= mcand_step_s;
                        mplier_r <= mplier_step_s;
                        count_r  <= count_step_s;
                        if (count_r == CNT_LAST) begin
                            out_r   <= acc_step_s[OUT_WIDTH-1:0];
                            state_r <= DONE;
                        end else begin
                            state_r <= BUSY;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_std_square.sv
// Self-checking bench for std_square (WIDTH=16): vector table, handshake corner sequences,
// and random operands (root/remainder round-trips when STD_SQUARE_ADDEND_EN is defined).
module tb_std_square;

    localparam int W    = 16;
    localparam int OW   = 2 * W;
    localparam int LAT  = W + 1;
`ifdef STD_SQUARE_ADDEND_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          go;
    logic [W-1:0]  in_v;
    logic [W:0]    addend_v;
    logic [OW-1:0] out_v;
    logic          done_v;

    int errors;
    int checks;

    std_square #(.WIDTH(W), .OUT_WIDTH(OW)) dut (
        .clk    (clk),
        .reset  (rst),
        .go     (go),
        .in     (in_v),
`ifdef STD_SQUARE_ADDEND_EN
        .addend (addend_v),
`endif
        .out    (out_v),
        .done   (done_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  a;
        logic [W:0]    b;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer square plus addend, truncated to the output width.
    function automatic logic [OW-1:0] model(input logic [W-1:0] a, input logic [W:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(a);
        if (ADD_EN) p = p + 64'(b);
        return p[OW-1:0];
    endfunction

    // Start one op, scramble the inputs after start, wait (bounded) for done, then drop go.
    task automatic run_op(input logic [W-1:0] a, input logic [W:0] b,
                          output logic [OW-1:0] got, output int lat);
        @(negedge clk);
        in_v = a; addend_v = b; go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_v = W'($urandom); addend_v = (W+1)'($urandom);
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done_v) break;
        end
        if (!done_v) begin
            errors++;
            checks++;
            $display("FAIL timeout: no done after %0d cycles, expected %0d", lat, LAT);
        end
        got = out_v;
        go  = 1'b0;
    endtask

    initial begin
        logic [OW-1:0] got;
        int            lat;
        int            edge_n;
        int            d1, d2;
        bit            seen;
        logic [W-1:0]  q;
        logic [W:0]    r;

        errors = 0; checks = 0;
        rst = 1'b1; go = 1'b0; in_v = '0; addend_v = '0;

        tbl.push_back('{16'd5,      17'd0, 32'd25});
        tbl.push_back('{16'hFFFF,   17'd0, 32'hFFFE_0001});
        tbl.push_back('{16'd0,      17'd0, 32'd0});
        tbl.push_back('{16'd1,      17'd0, 32'd1});
        tbl.push_back('{16'h8000,   17'd0, 32'h4000_0000});
        tbl.push_back('{16'h00FF,   17'd0, 32'h0000_FE01});
        tbl.push_back('{16'd46340,  17'd0, 32'd2147395600});
        if (ADD_EN) begin
            tbl.push_back('{16'd46340, 17'd88047, 32'h7FFF_FFFF});
            tbl.push_back('{16'd0,     17'h1FFFF, 32'h0001_FFFF});
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", 64'(out_v), 64'd0);
        chk("reset_done", 64'(done_v), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_done", 64'(done_v), 64'd0);

        // Table vectors: result, latency, and single-cycle done pulse
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, got, lat);
            chk($sformatf("tbl%0d_out", i), 64'(got), 64'(tbl[i].exp));
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(LAT));
            @(negedge clk);
            chk($sformatf("tbl%0d_pulse", i), 64'(done_v), 64'd0);
            chk($sformatf("tbl%0d_hold", i), 64'(out_v), 64'(tbl[i].exp));
        end

        // Back-to-back: go held, in=3 then in=4
        @(negedge clk);
        in_v = 16'd3; addend_v = '0; go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_v = 16'd4;
        edge_n = 0; d1 = -1; d2 = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            if (done_v) begin
                if (d1 < 0) begin
                    d1 = edge_n;
                    chk("b2b_out1", 64'(out_v), 64'd9);
                end else begin
                    d2 = edge_n;
                    chk("b2b_out2", 64'(out_v), 64'd16);
                    go = 1'b0;
                    break;
                end
            end
        end
        go = 1'b0;
        chk("b2b_first_lat", 64'(d1), 64'(LAT));
        chk("b2b_period", 64'(d2 - d1), 64'(W + 2));

        // Abort: in=7 completes, then in=9 with go dropped on BUSY cycle 8
        run_op(16'd7, 17'd0, got, lat);
        chk("abort_pre_out", 64'(got), 64'd49);
        @(negedge clk);
        in_v = 16'd9; go = 1'b1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done_v) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        chk("abort_out_kept", 64'(out_v), 64'd49);

        // Reset asserted mid-BUSY, between edges
        @(negedge clk);
        in_v = 16'd5; go = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out", 64'(out_v), 64'd0);
        chk("midrst_done", 64'(done_v), 64'd0);
        @(negedge clk);
        rst = 1'b0; go = 1'b0;
        run_op(16'd11, 17'd0, got, lat);
        chk("postrst_out", 64'(got), 64'd121);
        chk("postrst_lat", 64'(lat), 64'(LAT));

        // Random operands; with the addend feature, recombine random root/remainder pairs
        for (int n = 0; n < 20; n++) begin
            q = W'($urandom);
            r = ADD_EN ? (W+1)'($urandom_range(0, 2 * int'(q))) : '0;
            run_op(q, r, got, lat);
            chk($sformatf("rnd%0d_out q=%0d r=%0d", n, q, r), 64'(got), 64'(model(q, r)));
            chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'(LAT));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
